// File: rtl/prog_loader.sv
// prog_loader: buffers (address, word) entries into CPU memory, then resets, runs and halts the core
module prog_loader #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 11,
   parameter int FIFO_DEPTH = 8,
   parameter int ARM_CYCLES = 2,
   parameter int RUN_W      = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [ADDR_W-1:0] s_addr,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_auto,
   input  logic              s_last,
   input  logic              start,
   input  logic              abort,
   input  logic [RUN_W-1:0]  run_cycles,
   output logic              w_enable,
   output logic [ADDR_W-1:0] w_adrs,
   output logic [DATA_W-1:0] w_instruction,
   output logic              cpu_en,
   output logic              cpu_resetn,
   output logic              busy,
   output logic              done
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(ARM_CYCLES + 1);
   localparam int EW = ADDR_W + DATA_W + 1;
   localparam logic [CW-1:0] ARM_LAST = CW'(ARM_CYCLES - 1);
   localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, ARM = 3'd2, RUN = 3'd3, DONE = 3'd4;

   logic [2:0] state_q, state_d;
   logic [EW-1:0] fifo_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0] count_q, count_d;
   logic [ADDR_W-1:0] prev_q, prev_d, w_adrs_q, w_adrs_d, push_addr;
   logic [DATA_W-1:0] w_data_q, w_data_d;
   logic w_enable_q, w_enable_d, w_last_q, w_last_d;
   logic s_ready_q, s_ready_d, cpu_resetn_q, cpu_resetn_d;
   logic [CW-1:0] arm_cnt_q, arm_cnt_d;
   logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
   logic [EW-1:0] head;
   logic push, pop;

   assign push = s_valid && s_ready_q;
   assign push_addr = s_auto ? prev_q + ADDR_W'(1) : s_addr;
   assign head = fifo_q[rd_ptr_q];
   assign pop = state_q == LOAD && !w_last_q && !abort && count_q != '0;

   always_comb begin
      state_d = state_q;
      arm_cnt_d = arm_cnt_q;
      run_cnt_d = run_cnt_q;
      case (state_q)
         IDLE: state_d = push ? LOAD : (start && count_q == '0) ? ARM : IDLE;
         LOAD: state_d = abort ? DONE : w_last_q ? ARM : LOAD;
         ARM: begin
            state_d = abort ? DONE : (arm_cnt_q == ARM_LAST) ? RUN : ARM;
            arm_cnt_d = arm_cnt_q + CW'(1);
         end
         RUN: begin
            state_d = (abort || run_cnt_q == RUN_W'(1)) ? DONE : RUN;
            run_cnt_d = run_cnt_q - RUN_W'(run_cnt_q != '0);
         end
         DONE: state_d = push ? LOAD : start ? ARM : DONE;
         default: state_d = IDLE;
      endcase
      if (state_d == ARM && state_q != ARM) begin
         arm_cnt_d = '0;
         run_cnt_d = run_cycles;
      end
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
      if (state_q == LOAD && abort) begin
         rd_ptr_d = wr_ptr_d;
         count_d = '0;
      end
      prev_d = push ? push_addr : prev_q;
      w_enable_d = pop;
      w_last_d = pop && head[EW-1];
      w_adrs_d = pop ? head[EW-2:DATA_W] : w_adrs_q;
      w_data_d = pop ? head[DATA_W-1:0] : w_data_q;
      s_ready_d = (state_d == IDLE || state_d == LOAD || state_d == DONE) && count_d != (PW+1)'(FIFO_DEPTH);
      cpu_resetn_d = state_d != ARM;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q <= '0;
         prev_q <= '1;
         w_enable_q <= 1'b0;
         w_last_q <= 1'b0;
         w_adrs_q <= '0;
         w_data_q <= '0;
         s_ready_q <= 1'b0;
         cpu_resetn_q <= 1'b0;
         arm_cnt_q <= '0;
         run_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q <= count_d;
         prev_q <= prev_d;
         w_enable_q <= w_enable_d;
         w_last_q <= w_last_d;
         w_adrs_q <= w_adrs_d;
         w_data_q <= w_data_d;
         s_ready_q <= s_ready_d;
         cpu_resetn_q <= cpu_resetn_d;
         arm_cnt_q <= arm_cnt_d;
         run_cnt_q <= run_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr_q] <= {s_last, push_addr, s_data};
   end

   assign s_ready = s_ready_q;
   assign w_enable = w_enable_q;
   assign w_adrs = w_adrs_q;
   assign w_instruction = w_data_q;
   assign cpu_resetn = cpu_resetn_q;
   assign cpu_en = state_q == RUN;
   assign busy = state_q != IDLE && state_q != DONE;
   assign done = state_q == DONE;
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed and randomized load/run passes checked against a transaction-level scoreboard
module tb_prog_loader;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 11;
   localparam int RUN_W = 16;
   localparam int ARM_CYCLES = 2;

   logic clk = 1'b0, reset = 1'b1;
   logic s_valid = 1'b0, s_auto = 1'b0, s_last = 1'b0, start = 1'b0, abort = 1'b0;
   logic [ADDR_W-1:0] s_addr = '0;
   logic [DATA_W-1:0] s_data = '0;
   logic [RUN_W-1:0] run_cycles = '0;
   logic s_ready, w_enable, cpu_en, cpu_resetn, busy, done;
   logic [ADDR_W-1:0] w_adrs;
   logic [DATA_W-1:0] w_instruction;

   int n_checks = 0, n_errors = 0;
   logic [ADDR_W+DATA_W-1:0] exp_q[$];
   logic [ADDR_W+DATA_W-1:0] e;
   logic [ADDR_W-1:0] prev_addr = '1;
   int low_run = 0, last_low = 0, en_run = 0, last_en = 0, streak = 0, last_streak = 0, n_writes = 0;

   prog_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(8), .ARM_CYCLES(ARM_CYCLES), .RUN_W(RUN_W)) dut (
      .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_data(s_data),
      .s_auto(s_auto), .s_last(s_last), .start(start), .abort(abort), .run_cycles(run_cycles),
      .w_enable(w_enable), .w_adrs(w_adrs), .w_instruction(w_instruction), .cpu_en(cpu_en),
      .cpu_resetn(cpu_resetn), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
         low_run = 0;
         last_low = 0;
         en_run = 0;
         last_en = 0;
         streak = 0;
         last_streak = 0;
      end else begin
         check("wen_with_en", 64'(w_enable & cpu_en), 0);
         check("en_in_reset", 64'(cpu_en & ~cpu_resetn), 0);
         if (w_enable) begin
            n_writes++;
            streak++;
            if (exp_q.size() == 0) check("extra_write", 1, 0);
            else begin
               e = exp_q.pop_front();
               check("wr_addr", w_adrs, e[ADDR_W+DATA_W-1:DATA_W]);
               check("wr_data", w_instruction, e[DATA_W-1:0]);
            end
         end else if (streak != 0) begin
            last_streak = streak;
            streak = 0;
         end
         if (!cpu_resetn) low_run++;
         else if (low_run != 0) begin
            last_low = low_run;
            low_run = 0;
         end
         if (cpu_en) en_run++;
         else if (en_run != 0) begin
            last_en = en_run;
            en_run = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic is_auto, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic last);
      int k;
      k = 0;
      s_valid = 1'b1;
      s_auto = is_auto;
      s_addr = a;
      s_data = d;
      s_last = last;
      @(negedge clk);
      while (!s_ready && k < 50) begin
         k++;
         @(negedge clk);
      end
      check("push_ready", s_ready, 1);
      prev_addr = is_auto ? ADDR_W'((int'(prev_addr) + 1) % (1 << ADDR_W)) : a;
      exp_q.push_back({prev_addr, d});
      tick();
      s_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int k;
      k = 0;
      @(negedge clk);
      while (!done && k < budget) begin
         k++;
         @(negedge clk);
      end
      check("done_seen", done, 1);
      tick();
   endtask

   task automatic wait_en();
      int k;
      k = 0;
      @(negedge clk);
      while (!cpu_en && k < 30) begin
         k++;
         @(negedge clk);
      end
      check("en_seen", cpu_en, 1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      s_valid = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      prev_addr = '1;
      repeat (2) tick();
   endtask

   task automatic check_reset_values(input string t);
      check({t, "_w_enable"}, w_enable, 0);
      check({t, "_w_adrs"}, w_adrs, 0);
      check({t, "_w_instruction"}, w_instruction, 0);
      check({t, "_cpu_en"}, cpu_en, 0);
      check({t, "_cpu_resetn"}, cpu_resetn, 0);
      check({t, "_busy"}, busy, 0);
      check({t, "_done"}, done, 0);
      check({t, "_s_ready"}, s_ready, 0);
   endtask

   initial begin
      int k, n, w0;
      logic [RUN_W-1:0] rc;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_values("por");
      tick();
      reset = 1'b0;
      prev_addr = '1;
      @(posedge clk);
      @(negedge clk);
      check("rstn_after_reset", cpu_resetn, 1);
      check("ready_after_reset", s_ready, 1);
      tick();

      w0 = n_writes;
      run_cycles = 100;
      push(0, 1, 32'h8c01_0004, 0);
      push(0, 2, 32'h8c02_0008, 0);
      push(0, 5, 32'h0022_1820, 0);
      push(0, 6, 32'h0064_2820, 0);
      push(1, 0, 32'h0, 0);
      push(1, 0, 32'h0, 0);
      push(0, 100, 32'd10, 0);
      push(0, 101, 32'd11, 1);
      wait_done(300);
      check("t1_writes", n_writes - w0, 8);
      check("t1_streak", last_streak, 8);
      check("t1_arm", last_low, ARM_CYCLES);
      check("t1_run", last_en, 100);

      w0 = n_writes;
      run_cycles = 4;
      for (int i = 0; i < 12; i++) push(1, 0, $urandom, 1'(i == 11));
      wait_en();
      check("t2_ready_in_run", s_ready, 0);
      wait_done(100);
      check("t2_writes", n_writes - w0, 12);
      check("t2_streak", last_streak, 12);
      check("t2_drained", exp_q.size(), 0);

      run_cycles = 5;
      push(0, 2046, $urandom, 0);
      push(1, 0, $urandom, 0);
      push(1, 0, $urandom, 1);
      wait_done(100);
      check("t3_drained", exp_q.size(), 0);

      run_cycles = 3;
      pulse_start();
      wait_done(50);
      check("t5_arm", last_low, ARM_CYCLES);
      check("t5_run", last_en, 3);

      run_cycles = 50;
      pulse_start();
      wait_en();
      repeat (5) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_reset_values("mid_run");
      tick();
      reset = 1'b0;
      prev_addr = '1;
      @(posedge clk);
      @(negedge clk);
      check("t5_ready_idle", s_ready, 1);
      check("t5_rstn_idle", cpu_resetn, 1);
      tick();

      w0 = n_writes;
      run_cycles = 7;
      start = 1'b1;
      push(1, 0, 32'hcafe_f00d, 1);
      start = 1'b0;
      @(negedge clk);
      check("t6_busy", busy, 1);
      check("t6_not_arm", cpu_resetn, 1);
      tick();
      wait_done(60);
      check("t6_writes", n_writes - w0, 1);
      check("t6_run", last_en, 7);

      do_reset();
      w0 = n_writes;
      run_cycles = 0;
      pulse_start();
      wait_en();
      repeat (500) @(negedge clk);
      check("t4_free_run", cpu_en, 1);
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      @(negedge clk);
      check("t4_abort_en", cpu_en, 0);
      check("t4_abort_done", done, 1);
      check("t4_abort_rstn", cpu_resetn, 1);
      check("t4_no_writes", n_writes - w0, 0);
      tick();

      for (int it = 0; it < 25; it++) begin
         n = $urandom_range(1, 6);
         w0 = n_writes;
         rc = RUN_W'($urandom_range(1, 20));
         run_cycles = rc;
         if ($urandom_range(0, 3) == 0) begin
            n = 0;
            pulse_start();
         end else begin
            for (int j = 0; j < n; j++) begin
               repeat ($urandom_range(0, 2)) tick();
               push(1'($urandom_range(0, 1)), ADDR_W'($urandom), $urandom, 1'(j == n - 1));
            end
         end
         k = 0;
         @(negedge clk);
         while (cpu_resetn && k < 30) begin
            k++;
            @(negedge clk);
         end
         check("rand_arm_seen", cpu_resetn, 0);
         run_cycles = RUN_W'($urandom);
         wait_done(100);
         check("rand_arm", last_low, ARM_CYCLES);
         check("rand_run", last_en, rc);
         check("rand_writes", n_writes - w0, n);
         check("rand_drained", exp_q.size(), 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Parametrised program/data loader and run sequencer for the pipelined CPU top level.
- Accepts a buffered valid/ready stream of (address, word) entries and writes them into CPU memory through the w_enable/w_adrs/w_instruction port while the core is disabled.
- After the last entry, it pulses the core reset, enables the core for a programmable number of cycles, then halts it and reports done.
- Replaces hand-sequenced bench loading. Supports auto-increment addressing and repeated load/run passes.

Parameters:
DATA_W, 32, memory word / instruction width
ADDR_W, 11, memory address width
FIFO_DEPTH, 8, entries in input buffer (power of 2, >=2)
ARM_CYCLES, 2, cycles cpu_resetn held low before run
RUN_W, 16, width of run-cycle counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
s_valid  in  1  input entry valid
s_ready  out  1  loader can accept entry
s_addr  in  ADDR_W  explicit write address
s_data  in  DATA_W  word to write
s_auto  in  1  1: ignore s_addr, use previous write address + 1
s_last  in  1  entry is final of program image
start  in  1  begin run without loading (IDLE/DONE only)
abort  in  1  stop core immediately
run_cycles  in  RUN_W  cycles to keep cpu_en high; 0 = free-run until abort
w_enable  out  1  memory write strobe to core
w_adrs  out  ADDR_W  memory write address
w_instruction  out  DATA_W  memory write data
cpu_en  out  1  core enable
cpu_resetn  out  1  core reset, active low
busy  out  1  state != IDLE and != DONE
done  out  1  run finished, held until next load/start

Behaviour:
- Reset values:
  - state IDLE; FIFO empty; last-address register 2^ADDR_W-1, so the first auto entry goes to address 0.
  - w_enable 0, w_adrs 0, w_instruction 0.
  - cpu_en 0, cpu_resetn 0, busy 0, done 0, s_ready 0.
  - Reset mid-operation: all of the above values apply on the next edge; FIFO contents are discarded.
- cpu_resetn goes 1 on the first cycle after reset deasserts. It stays 1 except in ARM.
- s_ready = (state in IDLE, LOAD, DONE) && FIFO not full. Registered from state and count, no combinational path from s_valid.
- Push occurs on s_valid && s_ready. The stored address is resolved at push time:
  - s_auto=1: previous resolved address + 1, wrapping mod 2^ADDR_W.
  - s_auto=0: s_addr.
  - The previous-address register updates on every push.
- Push and pop in the same cycle are legal; count is unchanged.
- States:
  - IDLE:
    - push -> LOAD.
    - start with FIFO empty -> ARM.
    - start and push in the same cycle: push wins, start is ignored.
  - LOAD:
    - Each cycle the FIFO is non-empty, pop one entry.
    - Next cycle: w_enable=1, w_adrs/w_instruction = entry. Latency is 1 cycle pop-to-strobe; back-to-back entries give a continuous strobe.
    - When the popped entry has last=1, go to ARM after its write cycle.
    - start in LOAD is ignored.
    - FIFO empty without last: remain in LOAD, w_enable=0.
  - ARM:
    - cpu_resetn=0, cpu_en=0 for exactly ARM_CYCLES cycles.
    - Latch run_cycles on entry.
    - Then go to RUN.
  - RUN:
    - cpu_resetn=1, cpu_en=1.
    - With nonzero latched count, decrement each cycle. cpu_en is high for exactly that many cycles, then the state goes to DONE.
    - With zero latched count, stay in RUN until abort.
  - DONE:
    - cpu_en=0, done=1.
    - push -> LOAD, done cleared.
    - start -> ARM, done cleared.
- abort:
  - In ARM or RUN: next cycle DONE, cpu_en=0, cpu_resetn=1.
  - In LOAD: flush FIFO, go to DONE.
  - Ignored in IDLE/DONE.
- w_enable is never high while cpu_en is high. cpu_en is never high while cpu_resetn is 0.
- Address wrap: an auto entry after address 2^ADDR_W-1 writes address 0.

Test Plan:
1. Directed load and run:
   - Stimulus: entries (1, LOAD word), (2, LOAD word) explicit; (5, ADD word), (6, ADD word), then auto 7, 8 with NOP=0; (100,10); (101,11) last; run_cycles=100.
   - Required: eight single-cycle w_enable strobes with matching addr/data, in order.
   - Required: cpu_resetn low 2 cycles, cpu_en high exactly 100 cycles, done=1 afterwards.
2. Backpressure:
   - Stimulus: push 12 entries back-to-back with FIFO_DEPTH=8 while the FIFO is held.
   - Required: s_ready drops when 8 entries are queued; no entry lost or duplicated.
   - Required: strobes continuous once draining.
3. Auto-increment wrap:
   - Stimulus: explicit address 2046, then two auto entries (ADDR_W=11).
   - Required: writes go to 2046, 2047, 0.
4. Free run and abort:
   - Stimulus: start from IDLE with run_cycles=0; assert abort after 500 cycles.
   - Required: cpu_en drops the next cycle, done=1, no w_enable at any point.
5. Re-run and reset mid-run:
   - Stimulus: in DONE, pulse start with run_cycles=3.
   - Required: ARM 2 cycles, cpu_en 3 cycles, done.
   - Stimulus: then reset during RUN.
   - Required: every output at its reset value the following cycle, s_ready=0 until IDLE.
6. Same-cycle events:
   - Stimulus: start and s_valid together in IDLE.
   - Required: entry accepted, state LOAD, start ignored.
   - Stimulus: push and pop in the same cycle with count 3.
   - Required: count stays 3.
